if_fetch: RTL and testbench

- Instruction-fetch stage; supplies pc_out/inst_out to the decode stage.
- Reads each 32-bit instruction over a byte-serial memory port: four byte reads, assembled little-endian.
- Registers the result and holds it until downstream accepts it.
- Handles branch/jump redirects by aborting the fetch in flight and restarting at the target.

---
 rtl/if_fetch.sv | 166 ++++++++++++++++
 tb/tb_if_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction-fetch stage; assembles 32-bit words from a byte-serial
//            memory port. Define ICACHE_EN to add a direct-mapped word cache.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        stall_in,
    input  logic        branch_en_in,
    input  logic [31:0] branch_target_in,
    input  logic        mem_ack_in,
    input  logic [7:0]  mem_data_in,
    output logic        mem_rd_out,
    output logic [31:0] mem_addr_out,
    output logic        inst_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_nxt_pc;
    logic [1:0]  r_cnt;
    logic [1:0]  w_nxt_cnt;
    logic [23:0] r_buf;
    logic        w_take_byte;
    logic        w_load;
    logic        w_fill;
    logic        w_nxt_valid;
    logic [31:0] w_load_word;
    logic        w_hit;
    logic        w_nxt_hit;
    logic [31:0] w_hit_word;
    logic        w_unused;

    // Redirect outranks stall, acceptance and ack; a cache hit outranks memory.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_fetch_pc;
        w_nxt_cnt   = r_cnt;
        w_nxt_valid = inst_valid_out;
        w_take_byte = 1'b0;
        w_load      = 1'b0;
        w_fill      = 1'b0;
        w_load_word = c_NOP;
        if (branch_en_in) begin
            w_nxt_state = S_FETCH;
            w_nxt_pc    = {branch_target_in[31:2], 2'b00};
            w_nxt_cnt   = 2'd0;
            w_nxt_valid = 1'b0;
        end else if (r_state == S_HOLD) begin
            if (!stall_in) begin
                w_nxt_state = S_FETCH;
                w_nxt_valid = 1'b0;
            end
        end else if ((r_cnt == 2'd0) && w_hit) begin
            w_load      = 1'b1;
            w_load_word = w_hit_word;
            w_nxt_valid = 1'b1;
            w_nxt_pc    = r_fetch_pc + 32'd4;
            w_nxt_state = S_HOLD;
        end else if (mem_ack_in && mem_rd_out) begin
            w_take_byte = 1'b1;
            if (r_cnt == 2'd3) begin
                w_load      = 1'b1;
                w_fill      = 1'b1;
                w_load_word = {mem_data_in, r_buf};
                w_nxt_valid = 1'b1;
                w_nxt_cnt   = 2'd0;
                w_nxt_pc    = r_fetch_pc + 32'd4;
                w_nxt_state = S_HOLD;
            end else begin
                w_nxt_cnt = r_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state        <= S_FETCH;
            r_fetch_pc     <= RESET_PC;
            r_cnt          <= 2'd0;
            r_buf          <= 24'd0;
            pc_out         <= 32'd0;
            inst_out       <= c_NOP;
            inst_valid_out <= 1'b0;
            mem_rd_out     <= 1'b0;
            mem_addr_out   <= 32'd0;
        end else if (rdy_in) begin
            r_state        <= w_nxt_state;
            r_fetch_pc     <= w_nxt_pc;
            r_cnt          <= w_nxt_cnt;
            inst_valid_out <= w_nxt_valid;
            if (w_take_byte) begin
                case (r_cnt)
                    2'd0:    r_buf[7:0]   <= mem_data_in;
                    2'd1:    r_buf[15:8]  <= mem_data_in;
                    2'd2:    r_buf[23:16] <= mem_data_in;
                    default: ;
                endcase
            end
            if (w_load) begin
                pc_out   <= r_fetch_pc;
                inst_out <= w_load_word;
            end
            // Request is suppressed when the next word will be served by the cache.
            mem_rd_out   <= (w_nxt_state == S_FETCH) && !((w_nxt_cnt == 2'd0) && w_nxt_hit);
            mem_addr_out <= w_nxt_pc + {30'd0, w_nxt_cnt};
        end
    end

`ifdef ICACHE_EN
    localparam int c_IDX_W = $clog2(ICACHE_LINES);
    localparam int c_TAG_W = 30 - c_IDX_W;

    logic [31:0]        r_line_data [ICACHE_LINES];
    logic [c_TAG_W-1:0] r_line_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] r_line_vld;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_nxt_idx;

    assign w_idx      = r_fetch_pc[c_IDX_W+1:2];
    assign w_nxt_idx  = w_nxt_pc[c_IDX_W+1:2];
    assign w_hit      = r_line_vld[w_idx] && (r_line_tag[w_idx] == r_fetch_pc[31:c_IDX_W+2]);
    assign w_hit_word = r_line_data[w_idx];
    assign w_nxt_hit  = r_line_vld[w_nxt_idx] && (r_line_tag[w_nxt_idx] == w_nxt_pc[31:c_IDX_W+2]);
    assign w_unused   = ^{branch_target_in[1:0]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_line_vld <= '0;
        end else if (rdy_in && w_fill) begin
            r_line_vld[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_fill) begin
            r_line_data[w_idx] <= {mem_data_in, r_buf};
            r_line_tag[w_idx]  <= r_fetch_pc[31:c_IDX_W+2];
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_nxt_hit  = 1'b0;
    assign w_hit_word = c_NOP;
    assign w_unused   = ^{branch_target_in[1:0], w_fill, ICACHE_LINES};
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Scoreboard bench for if_fetch with a byte-serial memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        stall_in = 1'b1;
    logic        branch_en_in = 1'b0;
    logic [31:0] branch_target_in = 32'd0;
    logic        mem_ack_in = 1'b0;
    logic [7:0]  mem_data_in = 8'd0;
    logic        mem_rd_out;
    logic [31:0] mem_addr_out;
    logic        inst_valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_pc = 32'd0;
    int          gap = 0;
    int          gap_cnt = 0;
    bit          mem_en = 1'b0;
    logic        prev_v = 1'b0;
    logic        exp_rd;

    if_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(16)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
        .branch_en_in(branch_en_in), .branch_target_in(branch_target_in),
        .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
        .mem_rd_out(mem_rd_out), .mem_addr_out(mem_addr_out),
        .inst_valid_out(inst_valid_out), .pc_out(pc_out), .inst_out(inst_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[1:0], 6'b0};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder; acks while frozen carry corrupted data.
    always @(negedge clk) begin
        if (mem_en && mem_rd_out && !rdy_in) begin
            mem_ack_in  = 1'b1;
            mem_data_in = ~mem_byte(mem_addr_out);
        end else if (mem_en && mem_rd_out && gap_cnt == 0) begin
            mem_ack_in  = 1'b1;
            mem_data_in = mem_byte(mem_addr_out);
            gap_cnt     = gap;
        end else begin
            mem_ack_in = 1'b0;
            if (gap_cnt > 0) gap_cnt--;
        end
    end

    // Scoreboard: each new valid instruction is compared with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (inst_valid_out && !prev_v) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check_eq("sb_pc", pc_out, e[63:32]);
                check_eq("sb_inst", inst_out, e[31:0]);
            end
        end
        prev_v = inst_valid_out;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb.push_back({pc, word_at(pc)});
        exp_pc = pc + 32'd4;
    endtask

    task automatic consume();
        stall_in = 1'b0;
        tick();
        stall_in = 1'b1;
        push_exp(exp_pc);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !inst_valid_out; i++) tick();
        check_eq(tag, {31'd0, inst_valid_out}, 32'd1);
    endtask

    task automatic wait_acks(input int n, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < 200 && got < n; i++) begin
            tick();
            if (mem_ack_in && rdy_in) got++;
        end
        check_eq(tag, got, n);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        sb.delete();
        push_exp({tgt[31:2], 2'b00});
        branch_en_in     = 1'b1;
        branch_target_in = tgt;
        tick();
        branch_en_in     = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check_eq("rst_pc", pc_out, 32'd0);
        check_eq("rst_inst", inst_out, 32'h0000_0013);
        check_eq("rst_valid", {31'd0, inst_valid_out}, 32'd0);
        check_eq("rst_rd", {31'd0, mem_rd_out}, 32'd0);
        check_eq("rst_addr", mem_addr_out, 32'd0);
        tick();
        rst_in = 1'b1;
        mem_en = 1'b1;
        push_exp(32'd0);

        // First word: valid on the edge of the 4th ack, next request at 4
        wait_acks(4, "first_acks");
        check_eq("lat_4ack", {31'd0, inst_valid_out}, 32'd1);
        check_eq("next_addr", mem_addr_out, 32'd4);

        // Stall hold for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_pc", pc_out, 32'd0);
            check_eq("stall_inst", inst_out, 32'h0000_0013);
            check_eq("stall_valid", {31'd0, inst_valid_out}, 32'd1);
            check_eq("stall_rd", {31'd0, mem_rd_out}, 32'd0);
        end
        consume();
        check_eq("rel_valid", {31'd0, inst_valid_out}, 32'd0);
        check_eq("rel_rd", {31'd0, mem_rd_out}, 32'd1);
        check_eq("rel_addr", mem_addr_out, 32'd4);

        // Redirect after two acks of the fetch at 4
        wait_acks(2, "br_acks");
        redirect(32'h0000_0106);
        check_eq("br_addr", mem_addr_out, 32'h0000_0104);
        check_eq("br_rd", {31'd0, mem_rd_out}, 32'd1);
        wait_valid("br_valid");

        // Spaced acks with a frozen window
        gap = 3;
        consume();
        wait_acks(1, "gap_acks");
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("frz_addr", mem_addr_out, 32'h0000_0109);
            check_eq("frz_rd", {31'd0, mem_rd_out}, 32'd1);
        end
        rdy_in = 1'b1;
        wait_valid("gap_valid");
        gap = 0;

        // Address wrap from 0xFFFFFFFC
        redirect(32'hFFFF_FFFC);
        check_eq("wrap_vdrop", {31'd0, inst_valid_out}, 32'd0);
        wait_valid("wrap_valid");
        check_eq("wrap_next", mem_addr_out, 32'd0);
        consume();
`ifdef ICACHE_EN
        exp_rd = 1'b0;
`else
        exp_rd = 1'b1;
`endif
        check_eq("wrap_rd", {31'd0, mem_rd_out}, {31'd0, exp_rd});
        check_eq("wrap_addr", mem_addr_out, 32'd0);
        wait_valid("wrap0_valid");

        // Asynchronous reset in the middle of a fetch
        consume();
        wait_acks(1, "ar_acks");
        rst_in = 1'b0;
        #1;
        check_eq("ar_rd", {31'd0, mem_rd_out}, 32'd0);
        check_eq("ar_addr", mem_addr_out, 32'd0);
        check_eq("ar_valid", {31'd0, inst_valid_out}, 32'd0);
        sb.delete();
        tick();
        rst_in = 1'b1;
        push_exp(32'd0);
        wait_valid("ar_restart");

`ifdef ICACHE_EN
        for (int i = 0; i < 3; i++) begin
            consume();
            wait_valid("fill_valid");
        end
        redirect(32'd0);
        check_eq("hit_rd_pre", {31'd0, mem_rd_out}, 32'd0);
        tick();
        check_eq("hit_valid", {31'd0, inst_valid_out}, 32'd1);
        check_eq("hit_rd", {31'd0, mem_rd_out}, 32'd0);
        redirect(32'h0000_0040);
        check_eq("miss_rd", {31'd0, mem_rd_out}, 32'd1);
        wait_valid("miss_valid");
`endif

        tick();
        tick();
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
